// File: rtl/elevator_pkg.sv
// Shared floor labels, direction codes and scheduler state enumeration.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package elevator_pkg;

    localparam logic [1:0] FLOOR_F1 = 2'b00;
    localparam logic [1:0] FLOOR_F2 = 2'b01;
    localparam logic [1:0] FLOOR_F3 = 2'b10;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_SOS  = 2'd3
    } sched_state_t;

    // SOS reports "down" because the cabin is always sent to floor 1.
    function automatic logic [1:0] dir_of(input sched_state_t s);
        case (s)
            ST_UP:   dir_of = DIR_UP;
            ST_DOWN: dir_of = DIR_DOWN;
            ST_SOS:  dir_of = DIR_DOWN;
            default: dir_of = DIR_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/button_edge.sv
// Rising-edge detector for one synchronous call button.
// Latency: combinational pulse in the first cycle the button is seen high.
// Backpressure: none; a held button yields a single pulse.
module button_edge (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic rise
);

    logic prev;

    // Remember last cycle's level so only a 0->1 transition produces a pulse.
    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b0;
        else     prev <= button;
    end

    assign rise = button & ~prev;

endmodule

// File: rtl/request_scheduler.sv
// Three-floor call scheduler: latches button requests and picks the next goal floor.
// Latency: leds, direction and goal update one clk after the press/floor change.
// Backpressure: none; requests are level bits, repeats of a pending floor merge.
module request_scheduler
    import elevator_pkg::*;
#(
    parameter logic [1:0] labelF1 = FLOOR_F1,
    parameter logic [1:0] labelF2 = FLOOR_F2,
    parameter logic [1:0] labelF3 = FLOOR_F3
) (
    input  logic       clk,
    input  logic       button_reset,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic [1:0] floor,
    input  logic       moving,
    input  logic       door,
    input  logic       sos_mode,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic [1:0] goal_floor,
    output logic       goal_valid,
    output logic [1:0] direction
);

    logic [2:0]   rise;
    logic [2:0]   at_floor;
    logic [2:0]   serve;
    logic         cur_ok;
    logic [1:0]   cur_idx;
    logic [2:0]   pending_q, pending_nxt;
    logic [2:0]   above, below;
    logic [1:0]   up_idx, dn_idx, d_up, d_dn;
    logic [1:0]   up_lbl, dn_lbl;
    sched_state_t state_q, state_nxt;
    logic [1:0]   goal_q, goal_nxt;
    logic         vld_q, vld_nxt;

    button_edge u_edge1 (.clk(clk), .rst(button_reset), .button(button1), .rise(rise[0]));
    button_edge u_edge2 (.clk(clk), .rst(button_reset), .button(button2), .rise(rise[1]));
    button_edge u_edge3 (.clk(clk), .rst(button_reset), .button(button3), .rise(rise[2]));

    function automatic logic [1:0] idx_to_label(input logic [1:0] idx);
        case (idx)
            2'd0:    idx_to_label = labelF1;
            2'd1:    idx_to_label = labelF2;
            default: idx_to_label = labelF3;
        endcase
    endfunction

    assign at_floor = {floor == labelF3, floor == labelF2, floor == labelF1};
    assign cur_ok   = |at_floor;
    assign cur_idx  = at_floor[1] ? 2'd1 : (at_floor[2] ? 2'd2 : 2'd0);
    // A floor is served while the cabin stands there with the door open.
    assign serve    = at_floor & {3{~moving & door}};

    // Next pending set: SOS wipes everything, an invalid floor freezes it, serve beats a press.
    always_comb begin
        pending_nxt = pending_q;
        if (sos_mode)
            pending_nxt = 3'b000;
        else if (cur_ok)
            pending_nxt = (pending_q | rise) & ~serve;
    end

    // Split pending requests into those above and below the cabin and find the nearest of each.
    always_comb begin
        above = 3'b000;
        below = 3'b000;
        for (int i = 0; i < 3; i++) begin
            above[i] = pending_nxt[i] && (2'(i) > cur_idx);
            below[i] = pending_nxt[i] && (2'(i) < cur_idx);
        end
        up_idx = above[0] ? 2'd0 : (above[1] ? 2'd1 : 2'd2);
        dn_idx = below[2] ? 2'd2 : (below[1] ? 2'd1 : 2'd0);
        d_up   = up_idx - cur_idx;
        d_dn   = cur_idx - dn_idx;
        up_lbl = idx_to_label(up_idx);
        dn_lbl = idx_to_label(dn_idx);
    end

    // Next state and goal; reversals are only taken with the cabin stopped.
    always_comb begin
        state_nxt = state_q;
        goal_nxt  = goal_q;
        vld_nxt   = 1'b0;
        if (sos_mode) begin
            state_nxt = ST_SOS;
            goal_nxt  = labelF1;
            vld_nxt   = cur_ok && (floor != labelF1);
        end else if (state_q == ST_SOS) begin
            state_nxt = ST_IDLE;
        end else if (cur_ok) begin
            case (state_q)
                ST_IDLE: begin
                    if ((|above) && (!(|below) || (d_up <= d_dn))) begin
                        state_nxt = ST_UP;
                        goal_nxt  = up_lbl;
                    end else if (|below) begin
                        state_nxt = ST_DOWN;
                        goal_nxt  = dn_lbl;
                    end
                end
                ST_UP: begin
                    if (|above) begin
                        goal_nxt = up_lbl;
                    end else if (!moving) begin
                        if (|below) begin
                            state_nxt = ST_DOWN;
                            goal_nxt  = dn_lbl;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_DOWN: begin
                    if (|below) begin
                        goal_nxt = dn_lbl;
                    end else if (!moving) begin
                        if (|above) begin
                            state_nxt = ST_UP;
                            goal_nxt  = up_lbl;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
            vld_nxt = (state_nxt != ST_IDLE) && (goal_nxt != floor);
        end
    end

    // State, pending requests and goal registers.
    always_ff @(posedge clk) begin
        if (button_reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 3'b000;
            goal_q    <= labelF1;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            pending_q <= pending_nxt;
            goal_q    <= goal_nxt;
            vld_q     <= vld_nxt;
        end
    end

    assign led1       = pending_q[0];
    assign led2       = pending_q[1];
    assign led3       = pending_q[2];
    assign goal_floor = goal_q;
    assign goal_valid = vld_q;
    assign direction  = dir_of(state_q);

endmodule

// File: tb/tb_request_scheduler.sv
// Scenario bench for request_scheduler with a queue of hand-derived expectations.
// Latency: each step checks outputs one clk after its inputs are applied.
// Backpressure: n/a.
module tb_request_scheduler;

    logic       clk = 1'b0;
    logic       rst, b1, b2, b3, mov, dr, sos;
    logic [1:0] flr;
    logic       led1, led2, led3, goal_valid;
    logic [1:0] goal_floor, direction;

    typedef struct {
        string      tag;
        logic [2:0] led;
        logic [1:0] dir;
        logic [1:0] goal;
        logic       vld;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    request_scheduler dut (
        .clk(clk), .button_reset(rst),
        .button1(b1), .button2(b2), .button3(b3),
        .floor(flr), .moving(mov), .door(dr), .sos_mode(sos),
        .led1(led1), .led2(led2), .led3(led3),
        .goal_floor(goal_floor), .goal_valid(goal_valid), .direction(direction)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the expectation for the inputs just applied, clock once, then score.
    task automatic tick(input string tag, input logic [2:0] led, input logic [1:0] dir,
                        input logic [1:0] goal, input logic vld);
        exp_t e;
        e.tag = tag; e.led = led; e.dir = dir; e.goal = goal; e.vld = vld;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.tag, ".led"},  {5'd0, led3, led2, led1}, {5'd0, e.led});
        chk({e.tag, ".dir"},  {6'd0, direction},        {6'd0, e.dir});
        chk({e.tag, ".goal"}, {6'd0, goal_floor},       {6'd0, e.goal});
        chk({e.tag, ".vld"},  {7'd0, goal_valid},       {7'd0, e.vld});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1; b1 = 0; b2 = 0; b3 = 0; flr = 2'd0; mov = 0; dr = 0; sos = 0;
        tick("reset", 3'b000, 2'd0, 2'd0, 1'b0);

        // Idle at F1, call F3.
        rst = 0; b3 = 1;                 tick("f3_call",    3'b100, 2'd1, 2'd2, 1'b1);
        // Moving up from F1, F2 call retargets, arrival at F2 still moving skips ahead.
        b3 = 0; b2 = 1; mov = 1;         tick("f2_retgt",   3'b110, 2'd1, 2'd1, 1'b1);
        flr = 2'd1;                      tick("pass_f2",    3'b110, 2'd1, 2'd2, 1'b1);
        mov = 0; dr = 1;                 tick("serve_f2",   3'b100, 2'd1, 2'd2, 1'b1);
        b2 = 0; dr = 0; mov = 1;         tick("leave_f2",   3'b100, 2'd1, 2'd2, 1'b1);
        flr = 2'd2;                      tick("arrive_f3",  3'b100, 2'd1, 2'd2, 1'b0);
        mov = 0; dr = 1;                 tick("serve_f3",   3'b000, 2'd0, 2'd2, 1'b0);
        dr = 0;                          tick("idle_f3",    3'b000, 2'd0, 2'd2, 1'b0);

        // At F2 idle, F1 and F3 together: tie goes up first, then down.
        flr = 2'd1;                      tick("idle_f2",    3'b000, 2'd0, 2'd2, 1'b0);
        b1 = 1; b3 = 1;                  tick("tie_up",     3'b101, 2'd1, 2'd2, 1'b1);
        b3 = 0; mov = 1;                 tick("tie_move",   3'b101, 2'd1, 2'd2, 1'b1);
        flr = 2'd2;                      tick("tie_at_f3",  3'b101, 2'd1, 2'd2, 1'b0);
        mov = 0; dr = 1;                 tick("tie_rev",    3'b001, 2'd2, 2'd0, 1'b1);
        dr = 0; mov = 1;                 tick("dn_move",    3'b001, 2'd2, 2'd0, 1'b1);
        flr = 2'd1;                      tick("dn_f2",      3'b001, 2'd2, 2'd0, 1'b1);
        flr = 2'd0;                      tick("dn_at_f1",   3'b001, 2'd2, 2'd0, 1'b0);
        mov = 0; dr = 1;                 tick("serve_f1",   3'b000, 2'd0, 2'd0, 1'b0);
        dr = 0;                          tick("hold_b1_a",  3'b000, 2'd0, 2'd0, 1'b0);
                                         tick("hold_b1_b",  3'b000, 2'd0, 2'd0, 1'b0);

        // Press at the floor being served is ignored, and stays ignored while held.
        b1 = 0; flr = 2'd1; dr = 1;      tick("at_f2_open", 3'b000, 2'd0, 2'd0, 1'b0);
        b2 = 1;                          tick("ign_f2",     3'b000, 2'd0, 2'd0, 1'b0);
        dr = 0;                          tick("held_f2",    3'b000, 2'd0, 2'd0, 1'b0);

        // Invalid floor code freezes requests/state and drops goal_valid.
        b2 = 0; b3 = 1;                  tick("f3_from_f2", 3'b100, 2'd1, 2'd2, 1'b1);
        b3 = 0; flr = 2'd3; b1 = 1;      tick("bad_floor",  3'b100, 2'd1, 2'd2, 1'b0);
        b1 = 0; flr = 2'd1;              tick("floor_back", 3'b100, 2'd1, 2'd2, 1'b1);

        // SOS with F2/F3 pending.
        flr = 2'd0; b2 = 1;              tick("pend_23",    3'b110, 2'd1, 2'd1, 1'b1);
        b2 = 0; flr = 2'd1; sos = 1;     tick("sos_on",     3'b000, 2'd2, 2'd0, 1'b1);
        b3 = 1;                          tick("sos_press",  3'b000, 2'd2, 2'd0, 1'b1);
        flr = 2'd0;                      tick("sos_at_f1",  3'b000, 2'd2, 2'd0, 1'b0);
        sos = 0;                         tick("sos_off",    3'b000, 2'd0, 2'd0, 1'b0);
                                         tick("post_sos",   3'b000, 2'd0, 2'd0, 1'b0);

        // Reset mid-travel discards the request, including a press in the reset cycle.
        b3 = 0;                          tick("pre_rst",    3'b000, 2'd0, 2'd0, 1'b0);
        b3 = 1;                          tick("rst_call",   3'b100, 2'd1, 2'd2, 1'b1);
        b3 = 0; mov = 1; flr = 2'd1;     tick("rst_travel", 3'b100, 2'd1, 2'd2, 1'b1);
        rst = 1; b2 = 1;                 tick("mid_rst",    3'b000, 2'd0, 2'd0, 1'b0);
        rst = 0; b2 = 0;                 tick("after_rst",  3'b000, 2'd0, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/request_scheduler.md
REQUEST_SCHEDULER -- requirements
Module: request_scheduler

Interface
REQ-001 SHALL expose parameter labelF1, default 2'b00, floor-1 encoding.
REQ-002 SHALL expose parameter labelF2, default 2'b01, floor-2 encoding.
REQ-003 SHALL expose parameter labelF3, default 2'b10, floor-3 encoding.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port button_reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have ports button1/button2/button3  input  1 each  raw call button for floor 1/2/3, level, already synchronous to clk.
REQ-007 SHALL have port floor  input  2  current cabin floor from the movement stage.
REQ-008 SHALL have port moving  input  1  cabin in motion.
REQ-009 SHALL have port door  input  1  door open.
REQ-010 SHALL have port sos_mode  input  1  emergency, level.
REQ-011 SHALL have ports led1/led2/led3  output  1 each  pending request for floor 1/2/3.
REQ-012 SHALL have port goal_floor  output  2  target floor presented to the movement stage.
REQ-013 SHALL have port goal_valid  output  1  goal_floor meaningful.
REQ-014 SHALL have port direction  output  2  00 idle, 01 up, 10 down.

Function
REQ-015 SHALL latch a request for floor N on the rising edge of buttonN (0->1 between consecutive cycles); a held button SHALL NOT re-latch after clearing.
REQ-016 SHALL drive ledN = pending bit N, registered, visible the cycle after the press edge.
REQ-017 SHALL ignore a press edge for floor N when floor==N, moving==0 and door==1 (already served).
REQ-018 SHALL clear pending bit N in the cycle after floor==N, moving==0 and door==1 are all true; a simultaneous press edge for N SHALL lose to the clear.
REQ-019 SHALL implement FSM states IDLE, UP, DOWN, SOS; direction SHALL encode IDLE=00, UP=01, DOWN=10, SOS=10.
REQ-020 In IDLE with any pending bit, SHALL move to UP if the nearest pending floor is above, DOWN if below; equal distance SHALL choose UP.
REQ-021 In UP, goal_floor SHALL be the lowest pending floor strictly above floor; with none above, SHALL go DOWN if any pending below, else IDLE.
REQ-022 In DOWN, goal_floor SHALL be the highest pending floor strictly below floor; with none below, SHALL go UP if any pending above, else IDLE.
REQ-023 Direction reversal SHALL occur only while moving==0.
REQ-024 goal_floor/goal_valid SHALL be registered, updating one cycle after the pending/floor change that causes them.
REQ-025 goal_valid SHALL be 1 in UP/DOWN/SOS while the cabin is not at goal_floor, and 0 in IDLE; goal_floor SHALL hold its last value when goal_valid==0.
REQ-026 A new request ahead of the cabin in the current direction SHALL retarget goal_floor to the nearer floor next cycle, including while moving==1.
REQ-027 On sos_mode rising, SHALL enter SOS next cycle, clear all pending bits, and drive goal_floor=labelF1, goal_valid=1 until floor==labelF1.
REQ-028 While sos_mode==1, SHALL latch no requests; on sos_mode falling, SHALL return to IDLE.
REQ-029 floor==2'b11 SHALL hold pending bits and state unchanged and force goal_valid=0.

Reset
REQ-030 On button_reset==1 at a clk edge: state=IDLE, pending=000, led1..3=0, goal_floor=labelF1, goal_valid=0, direction=00, edge-detect history=0.
REQ-031 Reset mid-travel SHALL discard all requests; no request latched in the reset cycle.

Structure
REQ-032 Floor labels, the direction encoding and the FSM state enumeration SHALL live in shared package elevator_pkg.
REQ-033 Per-button rising-edge detection SHALL be one sub-module, button_edge, instantiated three times.

Verification
REQ-034 Reset, idle at F1, pulse button3 -> led3=1 next cycle, direction=01, goal_floor=2'b10, goal_valid=1.
REQ-035 Cabin moving up from F1 toward F3, at floor=F1 press button2 -> goal_floor becomes 2'b01 next cycle; after F2 stop with door=1, led2 clears, goal returns to 2'b10.
REQ-036 Cabin at F2 idle, press button1 and button3 in the same cycle -> direction=01, goal=F3 first; after service, direction=10, goal=F1.
REQ-037 Hold button2 at F2 with door=1, moving=0 -> led2 stays 0; hold button1 continuously through its service -> no re-latch.
REQ-038 Pending F2 and F3, assert sos_mode -> leds 000, direction=10, goal=F1; presses ignored until sos_mode deasserts, then IDLE.
REQ-039 Pending F3, assert button_reset for one cycle mid-travel -> all outputs at reset values the next cycle.
